// File: rtl/sr_pulse_ctrl.sv
// Front end for a NOR SR latch: turns raw bouncy set/clear requests into clean, exclusive s/r pulses.
// Define SR_SHADOW_EN to add q_shadow, a registered model of the latch state.
module sr_pulse_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int PULSE_W   = 2,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
`ifdef SR_SHADOW_EN
  output logic conflict,
  output logic q_shadow
`else
  output logic conflict
`endif
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] PW_PEN  = CNT_W'(PULSE_W - 2);

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;

  state_t           state;
  logic [1:0]       raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       db_lvl;
  logic [1:0]       ev;
  logic [1:0]       pend;
  logic [1:0]       take;
  logic [CNT_W-1:0] db_cnt [2];
  logic [CNT_W-1:0] pw_cnt;

  // Bit 0 is the set path, bit 1 the clear path throughout.
  assign raw = {clr_in, set_in};

  // An event fires on the same edge the debounced level rises, so the FSM sees it as pending one edge later.
  always_comb begin
    ev   = 2'b00;
    take = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ev[i] = sync_p1[i] & ~db_lvl[i] & (db_cnt[i] == DB_LAST);
    end
    if (state == IDLE) begin
      take = pend;
    end
  end

  // Stage p0/p1: synchronizer, then debounce and pending capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0   <= 2'b00;
      sync_p1   <= 2'b00;
      db_lvl    <= 2'b00;
      pend      <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_lvl[i] <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      pend <= (pend & ~take) | ev;
    end
  end

  // Stage p2: pulse sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      pw_cnt   <= '0;
`ifdef SR_SHADOW_EN
      q_shadow <= 1'b0;
`endif
    end else begin
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          pw_cnt <= '0;
          case (pend)
            2'b11: conflict <= 1'b1;
            2'b01: begin
              state <= SET_P;
              s     <= 1'b1;
              busy  <= 1'b1;
`ifdef SR_SHADOW_EN
              if (PULSE_W == 1) q_shadow <= 1'b1;
`endif
            end
            2'b10: begin
              state <= CLR_P;
              r     <= 1'b1;
              busy  <= 1'b1;
`ifdef SR_SHADOW_EN
              if (PULSE_W == 1) q_shadow <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
        SET_P: begin
          if (pw_cnt == PW_LAST) begin
            state <= GAP;
            s     <= 1'b0;
          end else begin
            pw_cnt <= pw_cnt + 1'b1;
`ifdef SR_SHADOW_EN
            if (pw_cnt == PW_PEN) q_shadow <= 1'b1;
`endif
          end
        end
        CLR_P: begin
          if (pw_cnt == PW_LAST) begin
            state <= GAP;
            r     <= 1'b0;
          end else begin
            pw_cnt <= pw_cnt + 1'b1;
`ifdef SR_SHADOW_EN
            if (pw_cnt == PW_PEN) q_shadow <= 1'b0;
`endif
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// Scoreboard bench for sr_pulse_ctrl: expected pulses (start edge, width) are queued when stimulus is
// applied and matched against pulses observed on s, r, conflict and busy.
module tb_sr_pulse_ctrl;
  localparam int DB = 4;
  localparam int PW = 2;
  localparam int LAT = DB + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic s, r, busy, conflict;
`ifdef SR_SHADOW_EN
  logic q_shadow;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {int start; int width;} obs_t;
  obs_t exp_s[$];
  obs_t exp_r[$];
  obs_t exp_c[$];
  obs_t exp_b[$];

  sr_pulse_ctrl #(.DB_CYCLES(DB), .PULSE_W(PW), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_in(set_in),
    .clr_in(clr_in),
    .s(s),
    .r(r),
    .busy(busy),
`ifdef SR_SHADOW_EN
    .conflict(conflict),
    .q_shadow(q_shadow)
`else
    .conflict(conflict)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic obs_t mk(input int start, input int width);
    obs_t o;
    o.start = start;
    o.width = width;
    return o;
  endfunction

  task automatic close_obs(input int k, input int start, input int width);
    obs_t  e;
    int    have;
    string nm;
    have = 0;
    e = mk(0, 0);
    case (k)
      0: begin nm = "s";        have = exp_s.size(); if (have > 0) e = exp_s.pop_front(); end
      1: begin nm = "r";        have = exp_r.size(); if (have > 0) e = exp_r.pop_front(); end
      2: begin nm = "conflict"; have = exp_c.size(); if (have > 0) e = exp_c.pop_front(); end
      default: begin nm = "busy"; have = exp_b.size(); if (have > 0) e = exp_b.pop_front(); end
    endcase
    if (have == 0) begin
      chk({nm, "_unexpected_start"}, start, -1);
    end else begin
      chk({nm, "_start"}, start, e.start);
      chk({nm, "_width"}, width, e.width);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor: samples on the falling edge, reports each completed high interval.
  initial begin
    logic [3:0] cur;
    logic [3:0] prev;
    int         st [4];
    prev = 4'b0000;
    for (int k = 0; k < 4; k++) st[k] = 0;
    forever begin
      @(negedge clk);
      cur = {busy, conflict, r, s};
      if (rst_n) begin
        chk("s_and_r", int'(s & r), 0);
        for (int k = 0; k < 4; k++) begin
          if (cur[k] && !prev[k]) st[k] = cyc;
          if (!cur[k] && prev[k]) close_obs(k, st[k], cyc - st[k]);
        end
        prev = cur;
      end else begin
        prev = 4'b0000;
      end
    end
  end

  initial begin
    int n;
    #23;
    chk("rst_s", int'(s), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_conflict", int'(conflict), 0);
`ifdef SR_SHADOW_EN
    chk("rst_q_shadow", int'(q_shadow), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_neg(3);

    // Single set request held high
    @(negedge clk);
    n = cyc;
    set_in = 1'b1;
    exp_s.push_back(mk(n + LAT, PW));
    exp_b.push_back(mk(n + LAT, PW + 1));
    wait_neg(LAT);
`ifdef SR_SHADOW_EN
    chk("t1_qsh_first", int'(q_shadow), 0);
`endif
    wait_neg(1);
`ifdef SR_SHADOW_EN
    chk("t1_qsh_last", int'(q_shadow), 1);
`endif
    wait_neg(12);
    set_in = 1'b0;
    wait_neg(12);

    // Clear glitch one cycle shorter than the debounce window
    @(negedge clk);
    clr_in = 1'b1;
    wait_neg(DB - 1);
    clr_in = 1'b0;
    wait_neg(15);

    // Simultaneous set and clear
    @(negedge clk);
    n = cyc;
    set_in = 1'b1;
    clr_in = 1'b1;
    exp_c.push_back(mk(n + LAT, 1));
    wait_neg(15);
`ifdef SR_SHADOW_EN
    chk("t3_qsh_kept", int'(q_shadow), 1);
`endif
    set_in = 1'b0;
    clr_in = 1'b0;
    wait_neg(12);

    // Clear event lands while the set pulse is active
    @(negedge clk);
    n = cyc;
    set_in = 1'b1;
    exp_s.push_back(mk(n + LAT, PW));
    exp_b.push_back(mk(n + LAT, PW + 1));
    wait_neg(1);
    clr_in = 1'b1;
    exp_r.push_back(mk(n + LAT + PW + 2, PW));
    exp_b.push_back(mk(n + LAT + PW + 2, PW + 1));
    wait_neg(10);
`ifdef SR_SHADOW_EN
    chk("t4_qsh_first", int'(q_shadow), 1);
`endif
    wait_neg(1);
`ifdef SR_SHADOW_EN
    chk("t4_qsh_last", int'(q_shadow), 0);
`endif
    wait_neg(10);
    set_in = 1'b0;
    clr_in = 1'b0;
    wait_neg(12);

    // Reset asserted during the first cycle of an s pulse
    @(negedge clk);
    set_in = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    chk("t5_s_before_rst", int'(s), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_s_in_rst", int'(s), 0);
    chk("t5_busy_in_rst", int'(busy), 0);
    #1;
    rst_n = 1'b1;
    n = cyc;
    exp_s.push_back(mk(n + LAT, PW));
    exp_b.push_back(mk(n + LAT, PW + 1));
    wait_neg(15);
    set_in = 1'b0;
    wait_neg(12);

    chk("s_left", exp_s.size(), 0);
    chk("r_left", exp_r.size(), 0);
    chk("conflict_left", exp_c.size(), 0);
    chk("busy_left", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
